// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: FSM state encoding, request owner, NOP fill value.
package rom_arb_pkg;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   typedef enum logic {OwnF, OwnL} owner_e;

   // Returned on a timed-out read so a fetch stage executes harmless "addi x0,x0,0".
   localparam logic [31:0] NopInstr = 32'h00000013;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester (fetch/load) and ROM-side signals of the arbiter.
// slave: arbiter view; master: requesters plus ROM view.
interface rom_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rsp_vld;
   logic [DW-1:0] f_rsp_data;
   logic          l_req;
   logic [AW-1:0] l_addr;
   logic          l_gnt;
   logic          l_rsp_vld;
   logic [DW-1:0] l_rsp_data;
   logic          rsp_err;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_dout;
   logic          rom_valid;
   logic          busy;

   modport slave (
      input  f_req, f_addr, l_req, l_addr, rom_dout, rom_valid,
      output f_gnt, f_rsp_vld, f_rsp_data, l_gnt, l_rsp_vld, l_rsp_data, rsp_err, rom_addr, busy
   );

   modport master (
      output f_req, f_addr, l_req, l_addr, rom_dout, rom_valid,
      input  f_gnt, f_rsp_vld, f_rsp_data, l_gnt, l_rsp_vld, l_rsp_data, rsp_err, rom_addr, busy
   );

endinterface

// File: rtl/rom_arb_pick.sv
// Owner select for the shared ROM port. ROM_ARB_RR_EN defined: round-robin on ties;
// otherwise fixed priority with F first. The last-owner register exists in both builds.
module rom_arb_pick
   import rom_arb_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   f_req_i,
   input  logic   l_req_i,
   input  logic   upd_i,
   output owner_e owner_o
);

   owner_e last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= OwnL;
      end else if (upd_i) begin
         last_q <= owner_o;
      end
   end

`ifdef ROM_ARB_RR_EN
   always_comb begin
      if (f_req_i && l_req_i) begin
         owner_o = (last_q == OwnF) ? OwnL : OwnF;
      end else if (f_req_i) begin
         owner_o = OwnF;
      end else begin
         owner_o = OwnL;
      end
   end
`else
   always_comb begin
      owner_o = (f_req_i || !l_req_i) ? OwnF : OwnL;
   end
`endif

   last_owner_tracks_grant: assert property (@(posedge clk) disable iff (reset)
      upd_i |=> (last_q == $past(owner_o)));

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM read port between fetch (F) and load (L) requesters.
// Arbitration policy is selected by ROM_ARB_RR_EN (see rom_arb_pick).
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned ROM_LAT = 1,
   parameter int unsigned TMO     = 15
) (
   input  logic                clk,
   input  logic                reset,
   rom_port_arbiter_if.slave   bus
);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        sel;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    tmo_q, tmo_d;
   logic          err_q, err_d;
   logic [DW-1:0] f_data_q, f_data_d;
   logic [DW-1:0] l_data_q, l_data_d;
   logic          accept;

   // RESP may accept directly so a held request sees a 3-cycle cadence.
   assign accept = (bus.f_req || bus.l_req) && (state_q == StIdle || state_q == StResp);

   rom_arb_pick u_pick (
      .clk     (clk),
      .reset   (reset),
      .f_req_i (bus.f_req),
      .l_req_i (bus.l_req),
      .upd_i   (accept),
      .owner_o (sel)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= OwnL;
         rom_addr_q <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         f_data_q   <= DW'(NopInstr);
         l_data_q   <= DW'(NopInstr);
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rom_addr_q <= rom_addr_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         f_data_q   <= f_data_d;
         l_data_q   <= l_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rom_addr_d = rom_addr_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      f_data_d   = f_data_q;
      l_data_d   = l_data_q;
      unique case (state_q)
         StIdle, StResp: begin
            if (accept) begin
               owner_d    = sel;
               rom_addr_d = (sel == OwnF) ? bus.f_addr : bus.l_addr;
               err_d      = 1'b0;
               tmo_d      = '0;
               state_d    = StIssue;
            end else begin
               state_d = StIdle;
            end
         end
         StIssue: begin
            cnt_d   = 8'(ROM_LAT - 1);
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (bus.rom_valid || tmo_q == 8'(TMO)) begin
               if (!bus.rom_valid) begin
                  err_d = 1'b1;
               end
               if (owner_q == OwnF) begin
                  f_data_d = bus.rom_valid ? bus.rom_dout : DW'(NopInstr);
               end else begin
                  l_data_d = bus.rom_valid ? bus.rom_dout : DW'(NopInstr);
               end
               state_d = StResp;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.f_gnt      = (state_q == StIssue) && (owner_q == OwnF);
      bus.l_gnt      = (state_q == StIssue) && (owner_q == OwnL);
      bus.f_rsp_vld  = (state_q == StResp) && (owner_q == OwnF);
      bus.l_rsp_vld  = (state_q == StResp) && (owner_q == OwnL);
      bus.rsp_err    = (state_q == StResp) && err_q;
      bus.busy       = (state_q != StIdle);
      bus.rom_addr   = rom_addr_q;
      bus.f_rsp_data = f_data_q;
      bus.l_rsp_data = l_data_q;
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a registered ROM model.
// Tie-order expectations follow ROM_ARB_RR_EN.
module tb_rom_port_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   rom_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   rom_port_arbiter #(.AW(32), .DW(32), .ROM_LAT(1), .TMO(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      case (a[15:0])
         16'h0000: rom_fn = 32'hb7000080;
         16'h0008: rom_fn = 32'h00a00093;
         16'h000c: rom_fn = 32'h00b00113;
         16'h0020: rom_fn = 32'h12345678;
         16'h0024: rom_fn = 32'hcafef00d;
         16'h0030: rom_fn = 32'hdeadbeef;
         default:  rom_fn = 32'h0;
      endcase
   endfunction

   always @(posedge clk) bus.rom_dout <= rom_fn(bus.rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_f;
      int         c;
      checks   = 0;
      failures = 0;
`ifdef ROM_ARB_RR_EN
      exp_f = 4'b0101;
`else
      exp_f = 4'b1111;
`endif
      reset         = 1'b1;
      bus.f_req     = 1'b0;
      bus.l_req     = 1'b0;
      bus.f_addr    = '0;
      bus.l_addr    = '0;
      bus.rom_valid = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_gnt", {30'd0, bus.f_gnt, bus.l_gnt}, 32'd0);
      check("rst_vld", {29'd0, bus.f_rsp_vld, bus.l_rsp_vld, bus.rsp_err}, 32'd0);
      check("rst_rom_addr", bus.rom_addr, 32'h0);
      check("rst_f_data", bus.f_rsp_data, 32'h00000013);
      check("rst_l_data", bus.l_rsp_data, 32'h00000013);
      reset = 1'b0;
      tick();

      // Single fetch from 0x0
      bus.f_addr = 32'h0;
      bus.f_req  = 1'b1;
      tick();
      check("t2_f_gnt", 32'(bus.f_gnt), 32'd1);
      check("t2_l_gnt", 32'(bus.l_gnt), 32'd0);
      check("t2_rom_addr", bus.rom_addr, 32'h0);
      check("t2_busy", 32'(bus.busy), 32'd1);
      bus.f_req = 1'b0;
      tick();
      check("t2_gnt_pulse", 32'(bus.f_gnt), 32'd0);
      check("t2_early_vld", 32'(bus.f_rsp_vld), 32'd0);
      tick();
      check("t2_f_vld", 32'(bus.f_rsp_vld), 32'd1);
      check("t2_f_data", bus.f_rsp_data, 32'hb7000080);
      check("t2_err", 32'(bus.rsp_err), 32'd0);
      check("t2_l_vld", 32'(bus.l_rsp_vld), 32'd0);
      tick();
      check("t2_vld_pulse", 32'(bus.f_rsp_vld), 32'd0);
      check("t2_idle", 32'(bus.busy), 32'd0);

      // Reset asserted mid-WAIT aborts the read
      bus.f_addr = 32'h20;
      bus.f_req  = 1'b1;
      tick();
      bus.f_req = 1'b0;
      tick();
      check("t1_in_wait", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t1_busy", 32'(bus.busy), 32'd0);
      check("t1_f_data", bus.f_rsp_data, 32'h00000013);
      check("t1_pulses", {28'd0, bus.f_gnt, bus.l_gnt, bus.f_rsp_vld, bus.l_rsp_vld}, 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_no_rsp", {30'd0, bus.f_rsp_vld, bus.busy}, 32'd0);
      end

      // Both requesters held: grant order depends on policy
      bus.f_addr = 32'h8;
      bus.l_addr = 32'hc;
      bus.f_req  = 1'b1;
      bus.l_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t3_f_gnt", 32'(bus.f_gnt), 32'(exp_f[k]));
         check("t3_l_gnt", 32'(bus.l_gnt), 32'(!exp_f[k]));
         if (k == 3) begin
            bus.f_req = 1'b0;
            bus.l_req = 1'b0;
         end
         tick();
         tick();
         if (exp_f[k]) begin
            check("t3_f_vld", 32'(bus.f_rsp_vld), 32'd1);
            check("t3_f_data", bus.f_rsp_data, 32'h00a00093);
         end else begin
            check("t3_l_vld", 32'(bus.l_rsp_vld), 32'd1);
            check("t3_l_data", bus.l_rsp_data, 32'h00b00113);
         end
      end
      tick();
      check("t3_idle", 32'(bus.busy), 32'd0);

      // ROM never valid: timeout after 1 + 15 WAIT cycles
      bus.rom_valid = 1'b0;
      bus.f_addr    = 32'h20;
      bus.f_req     = 1'b1;
      tick();
      check("t4_f_gnt", 32'(bus.f_gnt), 32'd1);
      bus.f_req = 1'b0;
      c = 1;
      while (c < 40 && !bus.f_rsp_vld) begin
         tick();
         c++;
      end
      check("t4_rsp_cycle", 32'(c), 32'd18);
      check("t4_err", 32'(bus.rsp_err), 32'd1);
      check("t4_nop", bus.f_rsp_data, 32'h00000013);
      tick();
      check("t4_err_pulse", 32'(bus.rsp_err), 32'd0);
      bus.rom_valid = 1'b1;

      // Load raised while fetch in flight
      bus.f_addr = 32'h24;
      bus.f_req  = 1'b1;
      tick();
      check("t5_f_gnt", 32'(bus.f_gnt), 32'd1);
      bus.f_req  = 1'b0;
      bus.l_addr = 32'h30;
      bus.l_req  = 1'b1;
      tick();
      check("t5_l_wait", 32'(bus.l_gnt), 32'd0);
      tick();
      check("t5_f_vld", 32'(bus.f_rsp_vld), 32'd1);
      check("t5_f_data", bus.f_rsp_data, 32'hcafef00d);
      check("t5_l_wait2", 32'(bus.l_gnt), 32'd0);
      tick();
      check("t5_l_gnt", 32'(bus.l_gnt), 32'd1);
      check("t5_rom_addr", bus.rom_addr, 32'h30);
      bus.l_req = 1'b0;
      tick();
      tick();
      check("t5_l_vld", 32'(bus.l_rsp_vld), 32'd1);
      check("t5_l_data", bus.l_rsp_data, 32'hdeadbeef);
      check("t5_f_held", bus.f_rsp_data, 32'hcafef00d);
      tick();

      // Back-to-back fetches
      bus.f_addr = 32'h20;
      bus.f_req  = 1'b1;
      tick();
      check("t6_gnt0", 32'(bus.f_gnt), 32'd1);
      check("t6_addr0", bus.rom_addr, 32'h20);
      bus.f_addr = 32'h24;
      tick();
      check("t6_addr_hold", bus.rom_addr, 32'h20);
      tick();
      check("t6_vld0", 32'(bus.f_rsp_vld), 32'd1);
      check("t6_data0", bus.f_rsp_data, 32'h12345678);
      check("t6_addr_hold2", bus.rom_addr, 32'h20);
      tick();
      check("t6_gnt1", 32'(bus.f_gnt), 32'd1);
      check("t6_addr1", bus.rom_addr, 32'h24);
      bus.f_req = 1'b0;
      tick();
      tick();
      check("t6_vld1", 32'(bus.f_rsp_vld), 32'd1);
      check("t6_data1", bus.f_rsp_data, 32'hcafef00d);
      tick();
      check("t6_idle", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
